nco_phase_gen: RTL and testbench

Numerically controlled phase generator that drives the sine and cosine phase inputs of a pair of `quarter_wave_sine_lookup` instances in the IQ modulator datapath. It holds a wide phase accumulator, truncates it to the lookup's phase width, and emits in-phase and quadrature (+90°) phase words. New frequency words are accepted through a valid/ready handshake and applied phase-continuously at the next accumulator wrap.

---
 rtl/nco_phase_gen_if.sv | 28 ++
 rtl/nco_phase_gen.sv | 179 +++++++++++++++++
 tb/tb_nco_phase_gen.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nco_phase_gen_if.sv
// -----------------------------------------------------------------------------
// nco_phase_gen_if
// Frequency-word handshake between a tuning source and nco_phase_gen.
//   i_fw        : frequency (tuning) word, unsigned, AW bits
//   i_fw_valid  : i_fw is valid
//   o_fw_ready  : the NCO can accept a frequency word
// The master modport is the source of tuning words; the slave modport is
// the NCO.
// -----------------------------------------------------------------------------
interface nco_phase_gen_if #(
  parameter int AW = 32
);
  logic [AW-1:0] i_fw;
  logic          i_fw_valid;
  logic          o_fw_ready;

  modport master (
    output i_fw,
    output i_fw_valid,
    input  o_fw_ready
  );

  modport slave (
    input  i_fw,
    input  i_fw_valid,
    output o_fw_ready
  );
endinterface

// File: rtl/nco_phase_gen.sv
// -----------------------------------------------------------------------------
// nco_phase_gen
// Numerically controlled phase generator feeding the sine/cosine phase inputs
// of a pair of quarter-wave lookups. A wide accumulator is truncated to PW
// bits; the cosine phase is the sine phase advanced by a quarter turn. New
// tuning words are captured through a valid/ready handshake and loaded into
// the active word only at an accumulator wrap, so the phase stays continuous.
//
// Parameters
//   AW : accumulator width (AW > PW)
//   PW : output phase width (matches the lookup phase width)
// Ports
//   i_clk        : clock, rising edge
//   i_reset_n    : asynchronous reset, active-low
//   i_ce         : clock enable for the accumulator
//   fw_if        : frequency-word handshake (slave side)
//   i_poff       : static phase offset added to both outputs
//   o_sin_phase  : sine phase word
//   o_cos_phase  : cosine phase word (sine + 2^(PW-2))
//   o_wrap       : accumulator carried out on this update
//   o_valid      : phase outputs were updated on the last edge
//
// Build option
//   NCO_DITHER_EN : when defined, a 16-bit Galois LFSR adds phase dither
//                   below the truncation point (outputs only; the
//                   accumulator and o_wrap are unaffected).
// -----------------------------------------------------------------------------
module nco_phase_gen #(
  parameter int AW = 32,
  parameter int PW = 12
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_ce,
  nco_phase_gen_if.slave fw_if,
  input  logic [PW-1:0] i_poff,
  output logic [PW-1:0] o_sin_phase,
  output logic [PW-1:0] o_cos_phase,
  output logic          o_wrap,
  output logic          o_valid
);

  localparam logic [PW-1:0] QUARTER = {2'b01, {(PW-2){1'b0}}};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [AW-1:0] fw_act_q, fw_act_d;
  logic [AW-1:0] fw_pend_q, fw_pend_d;
  logic [PW-1:0] sin_q, sin_d;
  logic [PW-1:0] cos_q, cos_d;
  logic          wrap_q, wrap_d;
  logic          valid_q, valid_d;

  logic [AW:0]   sum;
  logic          carry;
  logic          xfer;
  logic          apply;
  logic [AW-1:0] dith;

  // Top PW bits of the new accumulator value after adding the dither term.
  // With dither disabled the term is zero and this is plain truncation.
  function automatic logic [PW-1:0] phase_word(input logic [AW-1:0] nxt,
                                               input logic [AW-1:0] dv);
    logic [AW-1:0] s;
    s = nxt + dv;
    return s[AW-1 -: PW];
  endfunction

`ifdef NCO_DITHER_EN
  localparam int DW = ((AW - PW) < 16) ? (AW - PW) : 16;

  logic [15:0] lfsr_q, lfsr_d;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  always_comb begin
    lfsr_d = lfsr_q;
    if (i_ce) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign dith = {{(AW-DW){1'b0}}, lfsr_q[DW-1:0]};
`else
  assign dith = '0;
`endif

  assign sum   = {1'b0, acc_q} + {1'b0, fw_act_q};
  assign carry = sum[AW];
  assign xfer  = fw_if.i_fw_valid && (state_q == ST_IDLE);
  // A stalled accumulator (fw_act == 0) never wraps, so the pending word is
  // loaded on the next edge regardless of i_ce.
  assign apply = (state_q == ST_PEND) &&
                 ((i_ce && carry) || (fw_act_q == '0));

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    fw_act_d  = fw_act_q;
    fw_pend_d = fw_pend_q;
    sin_d     = sin_q;
    cos_d     = cos_q;
    wrap_d    = 1'b0;
    valid_d   = 1'b0;

    // Accumulator advances with the word that was active before this edge,
    // even on the edge that loads a new one.
    if (i_ce) begin
      acc_d   = sum[AW-1:0];
      wrap_d  = carry;
      valid_d = 1'b1;
      sin_d   = phase_word(sum[AW-1:0], dith) + i_poff;
      cos_d   = sin_d + QUARTER;
    end

    // A capture while IDLE is never applied on the same edge, so a transfer
    // coinciding with a wrap waits for the following wrap.
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          fw_pend_d = fw_if.i_fw;
          state_d   = ST_PEND;
        end
      end
      ST_PEND: begin
        if (apply) begin
          fw_act_d = fw_pend_q;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      fw_act_q  <= '0;
      fw_pend_q <= '0;
      sin_q     <= '0;
      cos_q     <= '0;
      wrap_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      fw_act_q  <= fw_act_d;
      fw_pend_q <= fw_pend_d;
      sin_q     <= sin_d;
      cos_q     <= cos_d;
      wrap_q    <= wrap_d;
      valid_q   <= valid_d;
    end
  end

  assign fw_if.o_fw_ready = (state_q == ST_IDLE);
  assign o_sin_phase      = sin_q;
  assign o_cos_phase      = cos_q;
  assign o_wrap           = wrap_q;
  assign o_valid          = valid_q;

endmodule

// File: tb/tb_nco_phase_gen.sv
module tb_nco_phase_gen;
  localparam int AW = 32;
  localparam int PW = 12;
  localparam longint MOD = 64'h1_0000_0000;

  logic          i_clk = 1'b0;
  logic          i_reset_n;
  logic          i_ce;
  logic [PW-1:0] i_poff;
  logic [PW-1:0] o_sin_phase;
  logic [PW-1:0] o_cos_phase;
  logic          o_wrap;
  logic          o_valid;

  nco_phase_gen_if #(.AW(AW)) fw_if ();

  nco_phase_gen #(.AW(AW), .PW(PW)) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_ce        (i_ce),
    .fw_if       (fw_if),
    .i_poff      (i_poff),
    .o_sin_phase (o_sin_phase),
    .o_cos_phase (o_cos_phase),
    .o_wrap      (o_wrap),
    .o_valid     (o_valid)
  );

  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  longint        m_acc, m_fw_act, m_fw_pend;
  bit            m_pend;
  logic [PW-1:0] m_sin, m_cos;
  bit            m_wrap, m_valid;

  task automatic model_reset();
    m_acc = 0; m_fw_act = 0; m_fw_pend = 0; m_pend = 0;
    m_sin = '0; m_cos = '0; m_wrap = 0; m_valid = 0;
  endtask

  task automatic model_edge();
    longint nxt;
    bit     carry, xfer, applies;
    nxt     = m_acc + m_fw_act;
    carry   = (nxt >= MOD);
    xfer    = fw_if.i_fw_valid && !m_pend;
    applies = m_pend && ((i_ce && carry) || (m_fw_act == 0));
    if (i_ce) begin
      m_acc   = nxt % MOD;
      m_wrap  = carry;
      m_valid = 1;
      m_sin   = 12'(((m_acc / 1048576) + longint'({52'd0, i_poff})) % 4096);
      m_cos   = 12'((longint'({52'd0, m_sin}) + 1024) % 4096);
    end else begin
      m_wrap  = 0;
      m_valid = 0;
    end
    if (applies) begin
      m_fw_act = m_fw_pend;
      m_pend   = 0;
    end else if (xfer) begin
      m_fw_pend = longint'({32'd0, fw_if.i_fw});
      m_pend    = 1;
    end
  endtask

  // Inputs change at the falling edge; the model follows each rising edge.
  task automatic tick();
    @(posedge i_clk);
    model_edge();
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0; i_ce = 1'b0; i_poff = '0;
    fw_if.i_fw = '0; fw_if.i_fw_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge i_clk);
    checks++;
    if ({o_sin_phase, o_cos_phase, o_wrap, o_valid, fw_if.o_fw_ready} !== {12'd0, 12'd0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_initial got=%h/%h/%b/%b/%b", o_sin_phase, o_cos_phase, o_wrap, o_valid, fw_if.o_fw_ready);
    end
    i_reset_n = 1'b1;
    // run with a word, then leave a second word pending before resetting
    i_ce = 1'b1;
    fw_if.i_fw = 32'h0100_0000; fw_if.i_fw_valid = 1'b1;
    tick();
    fw_if.i_fw_valid = 1'b0;
    repeat (8) tick();
    fw_if.i_fw = 32'h0300_0000; fw_if.i_fw_valid = 1'b1;
    tick();
    fw_if.i_fw_valid = 1'b0;
    checks++;
    if (fw_if.o_fw_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_pending_ready got=%b exp=0", fw_if.o_fw_ready);
    end
    #2 i_reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (o_sin_phase !== 12'd0 || o_cos_phase !== 12'd0) begin
      failures++;
      $display("FAIL reset_async_phase got=%0d/%0d exp=0/0", o_sin_phase, o_cos_phase);
    end
    checks++;
    if (o_wrap !== 1'b0 || o_valid !== 1'b0 || fw_if.o_fw_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_async_ctl got=%b%b%b exp=001", o_wrap, o_valid, fw_if.o_fw_ready);
    end
    @(negedge i_clk);
    i_reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (o_sin_phase !== 12'd0 || o_cos_phase !== 12'd1024 || o_valid !== 1'b1 ||
          o_wrap !== 1'b0 || fw_if.o_fw_ready !== 1'b1) begin
        failures++;
        $display("FAIL reset_idle_run cyc=%0d got=%0d/%0d/%b/%b/%b exp=0/1024/1/0/1",
                 k, o_sin_phase, o_cos_phase, o_valid, o_wrap, fw_if.o_fw_ready);
      end
    end
  endtask

  task automatic test_first_load();
    fw_if.i_fw = 32'h0010_0000; fw_if.i_fw_valid = 1'b1;
    tick();
    fw_if.i_fw_valid = 1'b0;
    checks++;
    if (fw_if.o_fw_ready !== 1'b0) begin
      failures++;
      $display("FAIL first_load_ready_low got=%b exp=0", fw_if.o_fw_ready);
    end
    tick();
    checks++;
    if (fw_if.o_fw_ready !== 1'b1) begin
      failures++;
      $display("FAIL first_load_applied got=%b exp=1", fw_if.o_fw_ready);
    end
    for (int k = 1; k <= 4100; k++) begin
      tick();
      checks++;
      if (o_sin_phase !== 12'(k % 4096) || o_cos_phase !== 12'((k + 1024) % 4096) ||
          o_wrap !== ((k % 4096) == 0)) begin
        failures++;
        $display("FAIL first_load_step k=%0d got=%0d/%0d/%b exp=%0d/%0d/%b", k,
                 o_sin_phase, o_cos_phase, o_wrap, k % 4096, (k + 1024) % 4096, (k % 4096) == 0);
      end
    end
  endtask

  task automatic test_retune();
    int n;
    int exp_sin;
    bit seen_wrap;
    n = 0;
    while (m_sin != 12'd100 && n < 5000) begin
      tick();
      n++;
    end
    checks++;
    if (o_sin_phase !== 12'd100) begin
      failures++;
      $display("FAIL retune_reach100 got=%0d exp=100", o_sin_phase);
    end
    fw_if.i_fw = 32'h0020_0000; fw_if.i_fw_valid = 1'b1;
    exp_sin = 100;
    seen_wrap = 0;
    for (int c = 0; c < 5000 && !seen_wrap; c++) begin
      tick();
      fw_if.i_fw_valid = 1'b0;
      exp_sin = (exp_sin + 1) % 4096;
      checks++;
      if (o_sin_phase !== 12'(exp_sin) || o_wrap !== (exp_sin == 0) ||
          fw_if.o_fw_ready !== (exp_sin == 0)) begin
        failures++;
        $display("FAIL retune_old_word got=%0d/%b/%b exp=%0d/%b/%b", o_sin_phase, o_wrap,
                 fw_if.o_fw_ready, exp_sin, exp_sin == 0, exp_sin == 0);
      end
      if (exp_sin == 0) seen_wrap = 1;
    end
    checks++;
    if (!seen_wrap) begin
      failures++;
      $display("FAIL retune_wrap_timeout got=none exp=wrap");
    end
    for (int j = 1; j <= 5; j++) begin
      tick();
      checks++;
      if (o_sin_phase !== 12'(2 * j)) begin
        failures++;
        $display("FAIL retune_new_word got=%0d exp=%0d", o_sin_phase, 2 * j);
      end
    end
  endtask

  task automatic test_ce();
    logic [PW-1:0] base;
    bit pat [4] = '{1, 0, 0, 1};
    int step_cnt;
    base = m_sin;
    step_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      i_ce = pat[i];
      tick();
      if (pat[i]) step_cnt++;
      checks++;
      if (o_valid !== pat[i] || o_sin_phase !== 12'(base + 2 * step_cnt) ||
          o_cos_phase !== 12'(base + 2 * step_cnt + 1024)) begin
        failures++;
        $display("FAIL ce_hold i=%0d got=%b/%0d exp=%b/%0d", i, o_valid, o_sin_phase,
                 pat[i], 12'(base + 2 * step_cnt));
      end
    end
    i_ce = 1'b1;
  endtask

  task automatic apply_reset();
    #2 i_reset_n = 1'b0;
    #1 model_reset();
    @(negedge i_clk);
    i_reset_n = 1'b1;
  endtask

  task automatic test_poff();
    apply_reset();
    i_ce = 1'b1; i_poff = '0;
    fw_if.i_fw = 32'd1500 << 20; fw_if.i_fw_valid = 1'b1;
    tick();
    fw_if.i_fw_valid = 1'b0;
    tick();
    i_poff = 12'd3072;
    tick();
    checks++;
    if (o_sin_phase !== 12'd476 || o_cos_phase !== 12'd1500) begin
      failures++;
      $display("FAIL poff_1500 got=%0d/%0d exp=476/1500", o_sin_phase, o_cos_phase);
    end
    tick();
    checks++;
    if (o_sin_phase !== 12'd1976 || o_cos_phase !== 12'd3000) begin
      failures++;
      $display("FAIL poff_3000 got=%0d/%0d exp=1976/3000", o_sin_phase, o_cos_phase);
    end
    i_poff = '0;
  endtask

  task automatic test_simul_wrap();
    apply_reset();
    i_ce = 1'b1;
    fw_if.i_fw = 32'h8000_0000; fw_if.i_fw_valid = 1'b1;
    tick();
    fw_if.i_fw_valid = 1'b0;
    tick();          // half-turn word loaded, acc = 0
    tick();          // acc = 2^31, next edge wraps
    checks++;
    if (o_sin_phase !== 12'd2048 || o_wrap !== 1'b0) begin
      failures++;
      $display("FAIL half_turn_mid got=%0d/%b exp=2048/0", o_sin_phase, o_wrap);
    end
    fw_if.i_fw = 32'h0010_0000; fw_if.i_fw_valid = 1'b1;
    tick();          // transfer on the wrap edge
    fw_if.i_fw_valid = 1'b0;
    checks++;
    if (o_wrap !== 1'b1 || o_sin_phase !== 12'd0 || fw_if.o_fw_ready !== 1'b0) begin
      failures++;
      $display("FAIL simul_wrap_edge got=%b/%0d/%b exp=1/0/0", o_wrap, o_sin_phase, fw_if.o_fw_ready);
    end
    tick();
    checks++;
    if (o_sin_phase !== 12'd2048 || o_wrap !== 1'b0 || fw_if.o_fw_ready !== 1'b0) begin
      failures++;
      $display("FAIL simul_wrap_hold got=%0d/%b/%b exp=2048/0/0", o_sin_phase, o_wrap, fw_if.o_fw_ready);
    end
    tick();
    checks++;
    if (o_sin_phase !== 12'd0 || o_wrap !== 1'b1 || fw_if.o_fw_ready !== 1'b1) begin
      failures++;
      $display("FAIL simul_wrap_apply got=%0d/%b/%b exp=0/1/1", o_sin_phase, o_wrap, fw_if.o_fw_ready);
    end
    for (int j = 1; j <= 3; j++) begin
      tick();
      checks++;
      if (o_sin_phase !== 12'(j) || o_wrap !== 1'b0) begin
        failures++;
        $display("FAIL simul_wrap_new got=%0d/%b exp=%0d/0", o_sin_phase, o_wrap, j);
      end
    end
  endtask

  task automatic test_random();
    int mode;
    for (int c = 0; c < 3000; c++) begin
      i_ce = ($urandom_range(0, 3) != 0);
      fw_if.i_fw_valid = ($urandom_range(0, 2) == 0);
      mode = int'($urandom_range(0, 5));
      case (mode)
        0:       fw_if.i_fw = 32'h0;
        1:       fw_if.i_fw = 32'h8000_0000;
        default: fw_if.i_fw = $urandom;
      endcase
      if ($urandom_range(0, 15) == 0) i_poff = 12'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        apply_reset();
        checks++;
        if ({o_sin_phase, o_cos_phase, o_wrap, o_valid, fw_if.o_fw_ready} !== {24'd0, 3'b001}) begin
          failures++;
          $display("FAIL random_reset got=%0d/%0d/%b/%b/%b", o_sin_phase, o_cos_phase,
                   o_wrap, o_valid, fw_if.o_fw_ready);
        end
      end
      tick();
      checks++;
      if ({o_sin_phase, o_cos_phase, o_wrap, o_valid, fw_if.o_fw_ready} !==
          {m_sin, m_cos, m_wrap, m_valid, !m_pend}) begin
        failures++;
        $display("FAIL random_cyc=%0d got=%0d/%0d/%b/%b/%b exp=%0d/%0d/%b/%b/%b", c,
                 o_sin_phase, o_cos_phase, o_wrap, o_valid, fw_if.o_fw_ready,
                 m_sin, m_cos, m_wrap, m_valid, !m_pend);
      end
    end
    fw_if.i_fw_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_load();
    test_retune();
    test_ce();
    test_poff();
    test_simul_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
